// File: rtl/tdm_clock_generator_pkg.sv
// ---------------------------------------------------------------------------
// tdm_clk_pkg
// Shared types and defaults for the TDM/I2S audio clock generator.
//   fs_mode_e   : frame sync style (I2S, left-justified, DSP/TDM pulse)
//   DEF_*       : default parameter values for the generator
//   decode_mode : maps the raw 2-bit mode field onto fs_mode_e; the unused
//                 encoding 3 behaves as I2S
// ---------------------------------------------------------------------------
package tdm_clk_pkg;

    typedef enum logic [1:0] {
        FS_I2S = 2'd0,
        FS_LJ  = 2'd1,
        FS_DSP = 2'd2
    } fs_mode_e;

    localparam int unsigned DEF_DIV_W         = 8;
    localparam int unsigned DEF_MAX_SLOT_BITS = 32;
    localparam int unsigned DEF_MAX_SLOTS     = 8;

    function automatic fs_mode_e decode_mode(input logic [1:0] raw);
        fs_mode_e m;
        case (raw)
            2'd1:    m = FS_LJ;
            2'd2:    m = FS_DSP;
            default: m = FS_I2S;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tdm_clock_generator_if.sv
// ---------------------------------------------------------------------------
// tdm_clk_if
// Run-time configuration and clock/position outputs of tdm_clock_generator.
//   enable_i          : run; low freezes all generator state
//   cfg_div_i         : bclk half-period minus 1, in clk_i cycles
//   cfg_slot_bits_i   : bits per slot minus 1
//   cfg_num_slots_i   : slots per frame minus 1
//   cfg_mode_i        : framing mode, fs_mode_e encoding (3 acts as I2S)
//   bclk_o / fs_o     : bit clock and frame sync
//   bclk_rise_o/fall_o: single-cycle strobes in the cycle bclk_o changes
//   frame_start_o     : single-cycle strobe on the fall entering slot 0 MSB
//   slot_o / bit_o    : current slot and bit (bit counts down, MSB first)
// master drives config and observes outputs; slave is the generator.
// ---------------------------------------------------------------------------
interface tdm_clk_if #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned SB_W  = 5,
    parameter int unsigned SL_W  = 3
);
    logic             enable_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic [SB_W-1:0]  cfg_slot_bits_i;
    logic [SL_W-1:0]  cfg_num_slots_i;
    logic [1:0]       cfg_mode_i;

    logic             bclk_o;
    logic             fs_o;
    logic             bclk_rise_o;
    logic             bclk_fall_o;
    logic             frame_start_o;
    logic [SL_W-1:0]  slot_o;
    logic [SB_W-1:0]  bit_o;

    modport master (
        output enable_i, cfg_div_i, cfg_slot_bits_i, cfg_num_slots_i, cfg_mode_i,
        input  bclk_o, fs_o, bclk_rise_o, bclk_fall_o, frame_start_o, slot_o, bit_o
    );

    modport slave (
        input  enable_i, cfg_div_i, cfg_slot_bits_i, cfg_num_slots_i, cfg_mode_i,
        output bclk_o, fs_o, bclk_rise_o, bclk_fall_o, frame_start_o, slot_o, bit_o
    );
endinterface

// File: rtl/tdm_clock_generator_bclk_divider.sv
// ---------------------------------------------------------------------------
// bclk_divider
// Half-period counter producing bclk and its edge strobes.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   enable_i      : count enable; low holds everything and clears strobes
//   cfg_div_i     : divider value captured at reset and on load_div_i
//   load_div_i    : pulsed with the frame-start fall; the reload done on that
//                   same edge already uses cfg_div_i
//   bclk_o        : bit clock (registered)
//   bclk_rise_o   : registered strobe, high in the cycle bclk_o becomes 1
//   bclk_fall_o   : registered strobe, high in the cycle bclk_o becomes 0
//   fall_tick_o   : combinational "this edge makes bclk fall", so the parent
//                   can update position state on the very same edge
// ---------------------------------------------------------------------------
module bclk_divider #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             load_div_i,
    output logic             bclk_o,
    output logic             bclk_rise_o,
    output logic             bclk_fall_o,
    output logic             fall_tick_o
);

    logic [DIV_W-1:0] cnt_reg,  cnt_next;
    logic [DIV_W-1:0] div_reg,  div_next;
    logic             bclk_reg, bclk_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             expire;
    logic             fall_tick;

    always_comb begin
        expire    = enable_i && (cnt_reg == '0);
        fall_tick = expire && bclk_reg;

        div_next  = load_div_i ? cfg_div_i : div_reg;
        cnt_next  = cnt_reg;
        bclk_next = bclk_reg;
        rise_next = expire && !bclk_reg;
        fall_next = fall_tick;

        if (expire) begin
            bclk_next = !bclk_reg;
            // div_next, not div_reg: a frame-start fall reloads with the new value
            cnt_next  = div_next;
        end else if (enable_i) begin
            cnt_next  = cnt_reg - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg  <= cfg_div_i;
            div_reg  <= cfg_div_i;
            bclk_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            div_reg  <= div_next;
            bclk_reg <= bclk_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    assign bclk_o      = bclk_reg;
    assign bclk_rise_o = rise_reg;
    assign bclk_fall_o = fall_reg;
    assign fall_tick_o = fall_tick;

endmodule

// File: rtl/tdm_clock_generator.sv
// ---------------------------------------------------------------------------
// tdm_clock_generator
// Audio serial clock generator: bit clock, frame sync for I2S, left-justified
// or DSP/TDM framing, edge strobes and slot/bit position, all in the clk_i
// domain so serialisers never sample bclk as data.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset; aborts the frame immediately
//   bus    : tdm_clk_if slave (enable, run-time config, clock/position outputs)
// Slot width, slot count, mode and divider are captured at reset and on the
// fall that starts each frame; mid-frame config changes wait for that fall.
// ---------------------------------------------------------------------------
module tdm_clock_generator
    import tdm_clk_pkg::*;
#(
    parameter int unsigned DIV_W         = DEF_DIV_W,
    parameter int unsigned MAX_SLOT_BITS = DEF_MAX_SLOT_BITS,
    parameter int unsigned MAX_SLOTS     = DEF_MAX_SLOTS
) (
    input  logic   clk_i,
    input  logic   rst_i,
    tdm_clk_if.slave bus
);

    localparam int unsigned SB_W = $clog2(MAX_SLOT_BITS);
    localparam int unsigned SL_W = $clog2(MAX_SLOTS);

    // Active frame configuration
    logic [SB_W-1:0] sb_reg,    sb_next;
    logic [SL_W-1:0] ns_reg,    ns_next;
    fs_mode_e        mode_reg,  mode_next;

    // Position and framing state
    logic [SL_W-1:0] slot_reg,  slot_next;
    logic [SB_W-1:0] bit_reg,   bit_next;
    logic            fs_reg,    fs_next;
    logic            fstart_reg, fstart_next;

    // Values for the edge in progress
    logic            fall_tick;
    logic            last_bit;
    logic            load_cfg;
    logic [SB_W-1:0] sb_eff;
    logic [SL_W-1:0] ns_eff;
    fs_mode_e        mode_eff;
    logic [SL_W-1:0] slot_adv;
    logic [SB_W-1:0] bit_adv;
    logic [SL_W-1:0] slot_follow;
    logic [SL_W:0]   half;
    logic            fs_adv;

    bclk_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (bus.enable_i),
        .cfg_div_i   (bus.cfg_div_i),
        .load_div_i  (load_cfg),
        .bclk_o      (bus.bclk_o),
        .bclk_rise_o (bus.bclk_rise_o),
        .bclk_fall_o (bus.bclk_fall_o),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        last_bit = (bit_reg == '0) && (slot_reg == ns_reg);
        // A fall leaving the last bit of the frame is the frame start
        load_cfg = fall_tick && last_bit;

        // Config governing the position being entered
        sb_eff   = load_cfg ? bus.cfg_slot_bits_i         : sb_reg;
        ns_eff   = load_cfg ? bus.cfg_num_slots_i         : ns_reg;
        mode_eff = load_cfg ? decode_mode(bus.cfg_mode_i) : mode_reg;

        // Position entered on this fall
        slot_adv = slot_reg;
        bit_adv  = bit_reg - SB_W'(1);
        if (bit_reg == '0) begin
            bit_adv  = sb_eff;
            slot_adv = last_bit ? '0 : slot_reg + SL_W'(1);
        end

        // Slot of the position after that one; I2S fs leads by one bclk
        slot_follow = slot_adv;
        if (bit_adv == '0) begin
            slot_follow = (slot_adv == ns_eff) ? '0 : slot_adv + SL_W'(1);
        end

        // Odd slot counts put the extra slot in the second half
        half = ({1'b0, ns_eff} + (SL_W+1)'(1)) >> 1;

        fs_adv = 1'b0;
        case (mode_eff)
            FS_LJ:   fs_adv = ({1'b0, slot_adv} < half);
            FS_DSP:  fs_adv = (slot_adv == ns_eff) && (bit_adv == '0);
            default: fs_adv = ({1'b0, slot_follow} >= half);
        endcase

        slot_next   = slot_reg;
        bit_next    = bit_reg;
        fs_next     = fs_reg;
        sb_next     = sb_reg;
        ns_next     = ns_reg;
        mode_next   = mode_reg;
        fstart_next = load_cfg;

        if (fall_tick) begin
            slot_next = slot_adv;
            bit_next  = bit_adv;
            fs_next   = fs_adv;
        end
        if (load_cfg) begin
            sb_next   = sb_eff;
            ns_next   = ns_eff;
            mode_next = mode_eff;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_reg     <= bus.cfg_slot_bits_i;
            ns_reg     <= bus.cfg_num_slots_i;
            mode_reg   <= decode_mode(bus.cfg_mode_i);
            // Park on the last bit of a notional previous frame so the
            // first fall is a frame start
            slot_reg   <= bus.cfg_num_slots_i;
            bit_reg    <= '0;
            fs_reg     <= (decode_mode(bus.cfg_mode_i) == FS_DSP);
            fstart_reg <= 1'b0;
        end else begin
            sb_reg     <= sb_next;
            ns_reg     <= ns_next;
            mode_reg   <= mode_next;
            slot_reg   <= slot_next;
            bit_reg    <= bit_next;
            fs_reg     <= fs_next;
            fstart_reg <= fstart_next;
        end
    end

    assign bus.fs_o          = fs_reg;
    assign bus.frame_start_o = fstart_reg;
    assign bus.slot_o        = slot_reg;
    assign bus.bit_o         = bit_reg;

endmodule

// File: doc/tdm_clock_generator.md
# tdm_clock_generator

Parametrised audio serial clock generator, the successor to the fixed 2-channel I2S clock generator. It divides the system clock into a bit clock and produces a frame sync for I2S, left-justified or DSP/TDM framing. Slot width, slot count and divider are selected at run time. It also emits single-cycle edge strobes and slot/bit position outputs, so serialisers in the same clock domain never have to sample `bclk_o` as data.

## Interface
- `DIV_W`, 8: width of the divider config.
- `MAX_SLOT_BITS`, 32: maximum bits per slot; power of two. `SB_W = $clog2(MAX_SLOT_BITS)`.
- `MAX_SLOTS`, 8: maximum slots per frame; power of two, ≥2. `SL_W = $clog2(MAX_SLOTS)`.
- `clk_i` in 1: system clock; one clock domain only.
- `rst_i` in 1: reset, synchronous, active-high.
- `enable_i` in 1: run; low freezes all state.
- `cfg_div_i` in DIV_W: bclk half-period minus 1, in `clk_i` cycles.
- `cfg_slot_bits_i` in SB_W: bits per slot minus 1.
- `cfg_num_slots_i` in SL_W: slots per frame minus 1.
- `cfg_mode_i` in 2: framing mode, type `fs_mode_e`.
- `bclk_o` out 1: bit clock.
- `fs_o` out 1: frame sync / LRCLK.
- `bclk_rise_o` out 1: 1-cycle strobe, in the cycle `bclk_o` becomes 1.
- `bclk_fall_o` out 1: 1-cycle strobe, in the cycle `bclk_o` becomes 0.
- `frame_start_o` out 1: 1-cycle strobe on the fall that starts slot 0, bit MSB.
- `slot_o` out SL_W: current slot index.
- `bit_o` out SB_W: current bit index, MSB-first, counting down.

## Operation
- **Active config.** Active config registers are loaded from `cfg_*` in reset and at every frame start, on the fall that starts the new frame. Changes mid-frame have no effect until the next frame.
- **Divider.** A half-period counter reloads to the active div and counts down while `enable_i` is high. At 0 it toggles `bclk_o`, reloads, and fires the matching edge strobe.
  - Half-period = div+1 cycles; div=0 gives clk/2.
  - A new div takes effect from the reload at the frame-start fall.
- **Position.** Position `(slot_o, bit_o)` advances on every fall; data changes on the fall and is sampled on the rise.
  - `bit_o` decrements. At 0 it reloads to slot_bits and `slot_o` increments.
  - When `slot_o == num_slots` and `bit_o == 0`, the next fall wraps to (0, slot_bits) and asserts `frame_start_o`.
- **fs_o** is registered and updated on each fall from the position being entered, with half = (num_slots+1)/2:
  - FS_I2S (0): `fs_o = (next-position slot ≥ half)`. `fs_o` is 0 for the left half and leads the slot boundary by one bclk.
  - FS_LJ (1): `fs_o = (current slot < half)`, aligned to the slot boundary.
  - FS_DSP (2): `fs_o = 1` only while the position is the last bit of the frame. This gives a one-bclk pulse before slot 0's MSB.
  - Value 3 is treated as FS_I2S.
- **Odd slot counts.** For I2S/LJ an odd slot count gives the extra slot to the second half; this is legal but not I2S-compliant.
- **enable_i low.** The counter, position, `bclk_o` and `fs_o` hold; all strobes are 0. Operation resumes exactly where it stopped.
- **Reset.** `rst_i` mid-frame aborts immediately. No partial-frame flush.

## Timing
- **Reset values.**
  - `bclk_o=0`; all strobes 0.
  - Half-period counter = `cfg_div_i`.
  - Position = (num_slots, 0), i.e. the last bit of the previous frame.
  - `fs_o` = 0 for I2S/LJ, 1 for DSP.
- **First edges after reset release with enable high.** First rise after div+1 cycles. First fall, which is also the frame start, after 2·(div+1) cycles.
- **Frame length.** (slot_bits+1)·(num_slots+1) bclk periods = that × 2·(div+1) `clk_i` cycles.
- **Coincident strobes.** `frame_start_o`, `bclk_fall_o` and the `fs_o`, `slot_o`, `bit_o` updates occur in the same cycle, with zero added latency relative to the `bclk_o` edge.

## Structure
- **Package `tdm_clk_pkg`:** `fs_mode_e` {FS_I2S=2'd0, FS_LJ=2'd1, FS_DSP=2'd2}, plus default parameter constants.
- **Sub-module `bclk_divider`:** half-period counter, `bclk_o` toggle, rise/fall strobes, with a `load_div` input pulsed at frame start. Framing and position logic stay in the top level.

## Test plan
- **I2S default.** div=6, slot_bits=31, num_slots=1, I2S → period 14 clk, frame 64 bclk. `fs_o` falls one bclk before slot 0 MSB and rises one bclk before slot 1 MSB.
- **DSP/TDM.** div=0, slot_bits=15, num_slots=7, DSP → `fs_o` high for exactly one bclk once every 128 bclk. `frame_start_o` pulses on the fall after `fs_o` goes high.
- **LJ.** slot_bits=23, num_slots=1 → `fs_o=1` during slot 0 bits 23..0. It toggles on the same fall as the `slot_o` change.
- **Mid-frame config change.** Change div 6→2 mid-frame → half-period stays 7 cycles until the next frame start, then becomes 3.
- **Enable gap.** Drop `enable_i` for 50 cycles mid-bit → outputs frozen and strobes 0. Remaining half-period count resumes unchanged.
- **Reset mid-frame.** Assert `rst_i` at slot 1 bit 10 → next cycle all outputs at reset values. The first frame start comes 2·(div+1) cycles after release.
